// File: rtl/lvt_port_scheduler_pkg.sv
// Shared types and helpers for the LVT memory port scheduler.
package lvt_port_scheduler_pkg;

    typedef enum logic {
        SLOT_READ  = 1'b0,
        SLOT_WRITE = 1'b1
    } slot_e;

    // Round-robin successor of idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/lvt_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping around.
module lvt_port_scheduler_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[IW'(j)]) begin
                found           = 1'b1;
                grant[IW'(j)]   = 1'b1;
                idx             = IW'(j);
            end
        end
    end

endmodule

// File: rtl/lvt_port_scheduler.sv
// Shares a 2-write/1-read LVT memory between NUM_REQ requesters; reads and writes use separate slots.
module lvt_port_scheduler
    import lvt_port_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             mem_rst,
    output logic                             wr0_en,
    output logic [ADDR_WIDTH-1:0]            wr0_addr,
    output logic [DATA_WIDTH-1:0]            wr0_data,
    output logic                             wr1_en,
    output logic [ADDR_WIDTH-1:0]            wr1_addr,
    output logic [DATA_WIDTH-1:0]            wr1_data,
    output logic                             rd0_en,
    output logic [ADDR_WIDTH-1:0]            rd0_addr,
    input  logic [DATA_WIDTH-1:0]            rd0_data,
    output logic                             rsp_valid,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data
);

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [NUM_REQ-1:0]  rd_req, wr_req, w1_req;
    logic [NUM_REQ-1:0]  rd_grant, w0_grant, w1_grant, grant;
    logic [ID_WIDTH-1:0] rd_idx, w0_idx, w1_idx, w1_ptr;
    logic                rd_found, w0_found, w1_found, w1_ok;
    logic [ID_WIDTH-1:0] rd_ptr, wr_ptr, rd_id;
    slot_e               last_slot, slot;
    logic                slot_act;

    assign rd_req = req_valid & ~req_we;
    assign wr_req = req_valid & req_we;

    lvt_port_scheduler_rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_rd_arb (
        .req(rd_req), .ptr(rd_ptr), .grant(rd_grant), .idx(rd_idx), .found(rd_found)
    );

    lvt_port_scheduler_rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_w0_arb (
        .req(wr_req), .ptr(wr_ptr), .grant(w0_grant), .idx(w0_idx), .found(w0_found)
    );

    // Second write searches onward from the first winner, excluding it.
    assign w1_req = wr_req & ~w0_grant;
    assign w1_ptr = ID_WIDTH'(rr_next(32'(w0_idx), NUM_REQ));

    lvt_port_scheduler_rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_w1_arb (
        .req(w1_req), .ptr(w1_ptr), .grant(w1_grant), .idx(w1_idx), .found(w1_found)
    );

    // An address clash blocks the second port so LVT write precedence never matters.
    assign w1_ok = w1_found && (addr_a[w1_idx] != addr_a[w0_idx]);

    // Slot selection: alternate when both kinds are pending.
    always_comb begin
        slot     = last_slot;
        slot_act = 1'b0;
        grant    = '0;
        if (rd_found && w0_found) begin
            slot_act = 1'b1;
            slot     = (last_slot == SLOT_WRITE) ? SLOT_READ : SLOT_WRITE;
        end else if (rd_found) begin
            slot_act = 1'b1;
            slot     = SLOT_READ;
        end else if (w0_found) begin
            slot_act = 1'b1;
            slot     = SLOT_WRITE;
        end
        if (slot_act) begin
            if (slot == SLOT_READ) grant = rd_grant;
            else                   grant = w0_grant | ({NUM_REQ{w1_ok}} & w1_grant);
        end
    end

    assign req_ready = grant & {NUM_REQ{rst_n}};
    assign mem_rst   = ~rst_n;
    assign rsp_data  = rsp_valid ? rd0_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr0_en    <= 1'b0;
            wr0_addr  <= '0;
            wr0_data  <= '0;
            wr1_en    <= 1'b0;
            wr1_addr  <= '0;
            wr1_data  <= '0;
            rd0_en    <= 1'b0;
            rd0_addr  <= '0;
            rd_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            last_slot <= SLOT_WRITE;
        end else begin
            wr0_en    <= 1'b0;
            wr1_en    <= 1'b0;
            rd0_en    <= 1'b0;
            rsp_valid <= rd0_en;
            rsp_id    <= rd_id;
            if (slot_act) begin
                last_slot <= slot;
                if (slot == SLOT_READ) begin
                    rd0_en   <= 1'b1;
                    rd0_addr <= addr_a[rd_idx];
                    rd_id    <= rd_idx;
                    rd_ptr   <= ID_WIDTH'(rr_next(32'(rd_idx), NUM_REQ));
                end else begin
                    wr0_en   <= 1'b1;
                    wr0_addr <= addr_a[w0_idx];
                    wr0_data <= wdata_a[w0_idx];
                    if (w1_ok) begin
                        wr1_en   <= 1'b1;
                        wr1_addr <= addr_a[w1_idx];
                        wr1_data <= wdata_a[w1_idx];
                        wr_ptr   <= ID_WIDTH'(rr_next(32'(w1_idx), NUM_REQ));
                    end else begin
                        wr_ptr   <= w1_ptr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lvt_port_scheduler.sv
// Self-checking bench for lvt_port_scheduler with a behavioural memory and scheduling model.
module tb_lvt_port_scheduler;

    localparam int unsigned NR    = 4;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0, req_we = '0, req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic             mem_rst, wr0_en, wr1_en, rd0_en, rsp_valid;
    logic [AW-1:0]    wr0_addr, wr1_addr, rd0_addr;
    logic [DW-1:0]    wr0_data, wr1_data, rd0_data, rsp_data;
    logic [IW-1:0]    rsp_id;

    lvt_port_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .mem_rst(mem_rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    // Memory model: read data appears the cycle after rd0_en; contents cleared by mem_rst.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;
    assign rd0_data = rd_q;
    always @(posedge clk or posedge mem_rst) begin
        if (mem_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            rd_q <= '0;
        end else begin
            if (wr0_en) mem[wr0_addr] <= wr0_data;
            if (wr1_en) mem[wr1_addr] <= wr1_data;
            if (rd0_en) rd_q <= mem[rd0_addr];
        end
    end

    // Requester state (held until granted) and reference model state.
    bit            pv [NR];
    bit            pwe[NR];
    logic [AW-1:0] pa [NR];
    logic [DW-1:0] pd [NR];
    logic [DW-1:0] ref_mem [DEPTH];
    int            rptr, wptr;
    bit            last_w;
    bit            e_w0, e_w1, e_rd;
    logic [AW-1:0] e_w0a, e_w1a, e_ra;
    logic [DW-1:0] e_w0d, e_w1d;
    bit            r0v, r1v;
    int            r0id, r1id;
    logic [DW-1:0] r0d, r1d;
    int            checks = 0, passed = 0;

    typedef struct {
        logic [NR-1:0]    load;
        logic [NR-1:0]    we;
        logic [NR-1:0]    exp;
        logic [NR*AW-1:0] addr;
    } row_t;
    row_t tbl [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic load(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!pv[i]) begin
            pv[i] = 1'b1; pwe[i] = we; pa[i] = a; pd[i] = d;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < int'(NR); i++) begin
            req_valid[i] = pv[i];
            req_we[i]    = pwe[i];
            req_addr[i*AW +: AW]  = pa[i];
            req_wdata[i*DW +: DW] = pd[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NR); i++) pv[i] = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        rptr = 0; wptr = 0; last_w = 1'b1;
        e_w0 = 0; e_w1 = 0; e_rd = 0; r0v = 0; r1v = 0;
    endtask

    // One cycle: check outputs from earlier grants, drive requests, check grants, advance model.
    task automatic step(output logic [NR-1:0] got);
        bit anyr, anyw, f;
        int slot, win, w0, w1;
        logic [NR-1:0] g;
        @(negedge clk);
        chk("wr0_en", 64'(wr0_en), 64'(e_w0));
        if (e_w0) begin
            chk("wr0_addr", 64'(wr0_addr), 64'(e_w0a));
            chk("wr0_data", 64'(wr0_data), 64'(e_w0d));
        end
        chk("wr1_en", 64'(wr1_en), 64'(e_w1));
        if (e_w1) begin
            chk("wr1_addr", 64'(wr1_addr), 64'(e_w1a));
            chk("wr1_data", 64'(wr1_data), 64'(e_w1d));
        end
        chk("rd0_en", 64'(rd0_en), 64'(e_rd));
        if (e_rd) chk("rd0_addr", 64'(rd0_addr), 64'(e_ra));
        chk("no_coissue", 64'(rd0_en & (wr0_en | wr1_en)), 64'(0));
        chk("rsp_valid", 64'(rsp_valid), 64'(r1v));
        if (r1v) begin
            chk("rsp_id", 64'(rsp_id), 64'(r1id));
            chk("rsp_data", 64'(rsp_data), 64'(r1d));
        end
        r1v = r0v; r1id = r0id; r1d = r0d;
        drive();
        #1;
        anyr = 0; anyw = 0;
        for (int i = 0; i < int'(NR); i++) if (pv[i]) begin
            if (pwe[i]) anyw = 1; else anyr = 1;
        end
        if (anyr && anyw) slot = last_w ? 1 : 2;
        else if (anyr)    slot = 1;
        else if (anyw)    slot = 2;
        else              slot = 0;
        g = '0; e_w0 = 0; e_w1 = 0; e_rd = 0; r0v = 0;
        win = 0; w0 = 0; w1 = 0;
        if (slot == 1) begin
            f = 0;
            for (int k = 0; k < int'(NR); k++) begin
                int j = (rptr + k) % int'(NR);
                if (!f && pv[j] && !pwe[j]) begin f = 1; win = j; end
            end
            g[win] = 1'b1;
            rptr = (win + 1) % int'(NR);
            last_w = 1'b0;
            e_rd = 1; e_ra = pa[win];
            r0v = 1; r0id = win; r0d = ref_mem[pa[win]];
        end else if (slot == 2) begin
            f = 0;
            for (int k = 0; k < int'(NR); k++) begin
                int j = (wptr + k) % int'(NR);
                if (!f && pv[j] && pwe[j]) begin f = 1; w0 = j; end
            end
            g[w0] = 1'b1;
            e_w0 = 1; e_w0a = pa[w0]; e_w0d = pd[w0];
            ref_mem[pa[w0]] = pd[w0];
            wptr = (w0 + 1) % int'(NR);
            f = 0;
            for (int k = 1; k < int'(NR); k++) begin
                int j = (w0 + k) % int'(NR);
                if (!f && pv[j] && pwe[j]) begin f = 1; w1 = j; end
            end
            if (f && pa[w1] != pa[w0]) begin
                g[w1] = 1'b1;
                e_w1 = 1; e_w1a = pa[w1]; e_w1d = pd[w1];
                ref_mem[pa[w1]] = pd[w1];
                wptr = (w1 + 1) % int'(NR);
            end
            last_w = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(g));
        got = req_ready;
        for (int i = 0; i < int'(NR); i++) if (g[i]) pv[i] = 1'b0;
    endtask

    // Asserts reset immediately, hammers random requests while checking quiet outputs.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        clear_model();
        for (int c = 0; c < cycles; c++) begin
            req_valid = NR'($urandom);
            req_we    = NR'($urandom);
            req_addr  = (NR*AW)'({$urandom, $urandom});
            #1;
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_strobes", 64'({wr0_en, wr1_en, rd0_en}), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_mem_rst", 64'(mem_rst), 64'(1));
            chk("rst_addrs", 64'({wr0_addr, wr1_addr, rd0_addr, rsp_id}), 64'(0));
            @(negedge clk);
        end
        rst_n = 1'b1;
        drive();
        #1;
        chk("rel_mem_rst", 64'(mem_rst), 64'(0));
    endtask

    logic [NR-1:0] got;

    initial begin
        tbl[0]  = '{4'b1111, 4'b1111, 4'b0011, {7'h23, 7'h22, 7'h21, 7'h20}};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b1100, '0};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b0011, {7'h33, 7'h32, 7'h31, 7'h30}};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b1100, '0};
        tbl[4]  = '{4'b1100, 4'b1100, 4'b0100, {7'h05, 7'h05, 7'h00, 7'h00}};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b1000, '0};
        tbl[6]  = '{4'b0011, 4'b0010, 4'b0001, {7'h00, 7'h00, 7'h06, 7'h05}};
        tbl[7]  = '{4'b0001, 4'b0000, 4'b0010, {7'h00, 7'h00, 7'h00, 7'h05}};
        tbl[8]  = '{4'b0010, 4'b0010, 4'b0001, {7'h00, 7'h00, 7'h07, 7'h00}};
        tbl[9]  = '{4'b0001, 4'b0000, 4'b0010, {7'h00, 7'h00, 7'h00, 7'h05}};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0001, '0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, '0};
        tbl[12] = '{4'b1111, 4'b0000, 4'b0010, {7'h33, 7'h32, 7'h31, 7'h30}};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0100, '0};
        tbl[14] = '{4'b0000, 4'b0000, 4'b1000, '0};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0001, '0};

        #2;
        do_reset(4);

        // Directed slot/arbitration sequence.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < int'(NR); i++)
                if (tbl[r].load[i]) load(i, tbl[r].we[i], tbl[r].addr[i*AW +: AW], $urandom);
            step(got);
            chk($sformatf("tbl_ready_%0d", r), 64'(got), 64'(tbl[r].exp));
        end
        for (int c = 0; c < 3; c++) step(got);

        // Write then read-after-write of the same address from another requester.
        load(0, 1'b1, 7'h11, 32'hDEADBEEF);
        step(got);
        load(1, 1'b0, 7'h11, '0);
        step(got);
        step(got);
        step(got);
        chk("raw_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("raw_rsp_id", 64'(rsp_id), 64'(1));
        chk("raw_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));

        // Reset one cycle after a read grant drops the response; memory reads back zero.
        load(2, 1'b0, 7'h11, '0);
        step(got);
        @(negedge clk);
        chk("rst_drop_rd0_en", 64'(rd0_en), 64'(1));
        do_reset(3);
        load(2, 1'b0, 7'h11, '0);
        step(got);
        step(got);
        step(got);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("post_rst_rsp_data", 64'(rsp_data), 64'(0));

        // Randomized traffic on a small address range to provoke clashes and RAW hazards.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < int'(NR); i++)
                if ($urandom_range(0, 9) < 4)
                    load(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            step(got);
            if (c == 300) do_reset(2);
        end
        for (int c = 0; c < 12; c++) step(got);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
